// File: rtl/iob_eth_wb_mem_sim.sv
// Wishbone B3 slave memory model for the Ethernet DMA master.
// Word-organised RAM of 2^(MEM_ADDR_W-2) x 32 bits with a programmable number
// of wait states before the first termination, linear incrementing bursts,
// error termination for out-of-range, misaligned or unsupported-burst access,
// and saturating counters of acked write and read beats.
//
// Ports
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   wb_adr_i, wb_sel_i      : byte address, byte lane enables
//   wb_we_i, wb_cyc_i       : write enable, cycle valid
//   wb_stb_i, wb_dat_i      : strobe, write data
//   wb_cti_i, wb_bte_i      : cycle type, burst type extension
//   wb_dat_o                : read data, zero outside read ack cycles
//   wb_ack_o, wb_err_o      : normal / error termination
//   wr_cnt_o, rd_cnt_o      : acked write / read beat counters (saturating)
//
// ack/err/dat are decoded from the registered BEAT state and the live
// cyc/stb so that master wait states and aborts suppress a termination in
// the very cycle they occur.
module iob_eth_wb_mem_sim #(
  parameter int unsigned MEM_ADDR_W = 14,
  parameter int unsigned WAIT_CYC   = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [31:0] wb_dat_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] rd_cnt_o
);

  localparam int unsigned WORD_AW = MEM_ADDR_W - 2;
  localparam int unsigned DEPTH   = 1 << WORD_AW;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned WAIT_W  = 4;
  localparam logic [2:0]  CTI_INCR = 3'b010;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, GAP} state_t;

  state_t              state_q, state_d;
  logic [WORD_AW-1:0]  addr_q, addr_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;
  logic [31:0]         mem [DEPTH];

  logic                req_err_c;
  logic                beat_c;
  logic                ack_c;
  logic                err_c;

  // Decode the access type once, at the start of a cycle
  assign req_err_c = (|wb_adr_i[31:MEM_ADDR_W]) || (|wb_adr_i[1:0]) ||
                     ((wb_bte_i != 2'b00) && (wb_cti_i == CTI_INCR));

  // A beat completes only while the master is actively strobing
  assign beat_c = (state_q == BEAT) && wb_cyc_i && wb_stb_i && !wb_rst_i;
  assign ack_c  = beat_c && !err_q;
  assign err_c  = beat_c && err_q;

  assign wb_ack_o = ack_c;
  assign wb_err_o = err_c;
  assign wb_dat_o = (ack_c && !wb_we_i) ? mem[addr_q] : 32'h0;
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

  // State and control registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d = wb_adr_i[MEM_ADDR_W-1:2];
          err_d  = req_err_c;
          if (WAIT_CYC == 0) begin
            state_d = BEAT;
          end else begin
            wcnt_d  = WAIT_W'(WAIT_CYC);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
          if (wcnt_q == WAIT_W'(1)) state_d = BEAT;
        end
      end
      BEAT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb_stb_i) begin
          // Incrementing bursts stay here; anything else (or an error) ends
          if (!err_q && (wb_cti_i == CTI_INCR)) begin
            addr_d = addr_q + WORD_AW'(1);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating beat counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (ack_c) begin
      if (wb_we_i && (wr_cnt_q != CNT_MAX)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (!wb_we_i && (rd_cnt_q != CNT_MAX)) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
    end
  end

  // Byte-lane write; contents survive reset
  always_ff @(posedge wb_clk_i) begin
    if (ack_c && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[addr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule
